// File: rtl/dynamic_pattern_pkg.sv
// Shared constants and FSM state type for the
// serial pattern transmitter slice.
package dynamic_pattern_pkg;

  localparam int PAT_W = 5;
  localparam int CNT_W = 8;
  localparam int GAP_W = 4;
  localparam int BIT_W = $clog2(PAT_W + 1);

  localparam logic [PAT_W-1:0] DEFAULT_PAT =
    5'b01101;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } tx_state_t;

endpackage

// File: rtl/pattern_piso.sv
// Parallel-in serial-out shift register, MSB first.
// Ports: clk, rst (async low), load, shift,
//   load_val (parallel word), msb (current head bit).
module pattern_piso
  import dynamic_pattern_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] load_val,
  output logic             msb
);

  logic [PAT_W-1:0] sr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= load_val;
    end else if (shift) begin
      sr <= {sr[PAT_W-2:0], 1'b0};
    end
  end

  assign msb = sr[PAT_W-1];

endmodule

// File: rtl/dynamic_pattern_tx.sv
// Serial pattern transmitter: repeats a PAT_W-bit
// pattern MSB-first with optional idle gaps.
// Ports: clk, rst (async low), cfg_we/cfg_pattern
//   (pattern reg write), start/repeat_n/gap_n (burst
//   request), stall_i (freeze), d_o/v_o (serial
//   stream), busy, done (completion pulse).
module dynamic_pattern_tx
  import dynamic_pattern_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             start,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap_n,
  input  logic             stall_i,
  output logic             d_o,
  output logic             v_o,
  output logic             busy,
  output logic             done
);

  tx_state_t        state;
  logic [PAT_W-1:0] pat_q;
  logic [PAT_W-1:0] burst_pat;
  logic [CNT_W-1:0] rep_left;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt;
  logic [BIT_W-1:0] bit_cnt;

  logic [PAT_W-1:0] new_pat;
  logic             accept;
  logic             last_bit;
  logic             last_rep;
  logic             gap_end;
  logic             sh_load;
  logic             sh_shift;
  logic [PAT_W-1:0] sh_val;
  logic             sh_msb;

  // Same-cycle write bypasses into a new burst.
  assign new_pat = cfg_we ? cfg_pattern : pat_q;

  // busy still high in IDLE marks the closing
  // cycle of a burst; start is ignored there.
  assign accept = (state == IDLE) && !busy &&
                  start && !stall_i &&
                  (repeat_n != '0);

  assign last_bit =
    (bit_cnt == BIT_W'(PAT_W - 1));
  assign last_rep = (rep_left == CNT_W'(1));
  assign gap_end  = (gap_cnt == GAP_W'(1));

  // The first bit goes out on the accept edge,
  // so the shifter is loaded pre-shifted there.
  always_comb begin
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_val   = burst_pat;
    if (!stall_i) begin
      unique case (1'b1)
        (state == IDLE): begin
          if (accept) begin
            sh_load = 1'b1;
            sh_val  =
              {new_pat[PAT_W-2:0], 1'b0};
          end
        end
        (state == SEND): begin
          if (last_bit && !last_rep &&
              gap_q == '0) begin
            sh_load = 1'b1;
          end else begin
            sh_shift = 1'b1;
          end
        end
        (state == GAP): begin
          sh_load = gap_end;
        end
        default: ;
      endcase
    end
  end

  pattern_piso u_piso (
    .clk      (clk),
    .rst      (rst),
    .load     (sh_load),
    .shift    (sh_shift),
    .load_val (sh_val),
    .msb      (sh_msb)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pat_q     <= DEFAULT_PAT;
      burst_pat <= '0;
      rep_left  <= '0;
      gap_q     <= '0;
      gap_cnt   <= '0;
      bit_cnt   <= '0;
      d_o       <= 1'b0;
      v_o       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (cfg_we) begin
        pat_q <= cfg_pattern;
      end
      if (stall_i) begin
        v_o  <= 1'b0;
        done <= 1'b0;
      end else begin
        v_o  <= 1'b0;
        d_o  <= 1'b0;
        done <= 1'b0;
        unique case (state)
          IDLE: begin
            if (busy) begin
              busy <= 1'b0;
              done <= 1'b1;
            end else if (start) begin
              if (repeat_n == '0) begin
                done <= 1'b1;
              end else begin
                burst_pat <= new_pat;
                rep_left  <= repeat_n;
                gap_q     <= gap_n;
                bit_cnt   <= BIT_W'(1);
                d_o       <= new_pat[PAT_W-1];
                v_o       <= 1'b1;
                busy      <= 1'b1;
                state     <= SEND;
              end
            end
          end
          SEND: begin
            d_o <= sh_msb;
            v_o <= 1'b1;
            if (last_bit) begin
              bit_cnt  <= '0;
              rep_left <= rep_left - CNT_W'(1);
              if (last_rep) begin
                state <= IDLE;
              end else if (gap_q != '0) begin
                gap_cnt <= gap_q;
                state   <= GAP;
              end
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
          GAP: begin
            if (gap_end) begin
              gap_cnt <= '0;
              state   <= SEND;
            end else begin
              gap_cnt <= gap_cnt - GAP_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dynamic_pattern_tx.sv
// Self-checking bench for dynamic_pattern_tx:
// slot-queue reference model plus directed bursts.
module tb_dynamic_pattern_tx;
  import dynamic_pattern_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cfg_we = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] repeat_n = '0;
  logic [GAP_W-1:0] gap_n = '0;
  logic             stall_i = 1'b0;
  logic             d_o;
  logic             v_o;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  dynamic_pattern_tx dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .start       (start),
    .repeat_n    (repeat_n),
    .gap_n       (gap_n),
    .stall_i     (stall_i),
    .d_o         (d_o),
    .v_o         (v_o),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Model: a burst is a list of output slots;
  // every non-stalled edge shows the next slot.
  typedef struct packed {
    logic d;
    logic v;
    logic b;
    logic dn;
  } slot_t;

  slot_t            mq[$];
  slot_t            m_s;
  logic [PAT_W-1:0] pat_m = DEFAULT_PAT;
  logic [PAT_W-1:0] m_p;
  logic ed = 1'b0;
  logic ev = 1'b0;
  logic eb = 1'b0;
  logic edn = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      mq.delete();
      pat_m = DEFAULT_PAT;
      {ed, ev, eb, edn} = 4'b0;
    end else begin
      m_p = cfg_we ? cfg_pattern : pat_m;
      if (cfg_we) pat_m = cfg_pattern;
      if (stall_i) begin
        ev  = 1'b0;
        edn = 1'b0;
      end else begin
        if (mq.size() == 0 && start) begin
          for (int r = 0; r < int'(repeat_n);
               r++) begin
            for (int b = PAT_W - 1; b >= 0;
                 b--)
              mq.push_back({m_p[b], 3'b110});
            if (r < int'(repeat_n) - 1)
              for (int g = 0; g < int'(gap_n);
                   g++)
                mq.push_back(4'b0010);
          end
          mq.push_back(4'b0001);
        end
        if (mq.size() != 0) begin
          m_s = mq.pop_front();
          {ed, ev, eb, edn} = m_s;
        end else begin
          {ed, ev, eb, edn} = 4'b0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst && chk_en) begin
      checks++;
      if ({d_o, v_o, busy, done} !==
          {ed, ev, eb, edn}) begin
        errors++;
        if (errors <= 20)
          $display(
            "FAIL model t=%0t dvbd got %b%b%b%b required %b%b%b%b",
            $time, d_o, v_o, busy, done,
            ed, ev, eb, edn);
      end
    end
  end

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d",
               nm, act, exp);
    end
  endtask

  logic [31:0] r_bits;
  logic [4:0]  win;
  int r_nv, r_nb, r_nd, r_didx, r_fv, r_match;

  // Drive one start and observe ncyc cycles.
  task automatic burst(input int rn, gn, ncyc,
                       input int we_at,
                       input logic [4:0] wpat,
                       input int st_at, st_len,
                       input int rst_at, sa_at);
    @(negedge clk);
    start    = 1'b1;
    repeat_n = CNT_W'(rn);
    gap_n    = GAP_W'(gn);
    r_bits = '0; win = '0;
    r_nv = 0; r_nb = 0; r_nd = 0;
    r_didx = 0; r_fv = 0; r_match = 0;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (v_o) begin
        r_bits = {r_bits[30:0], d_o};
        win = {win[3:0], d_o};
        r_nv++;
        if (r_fv == 0) r_fv = i;
        if (r_nv >= 5 && win == 5'b01101)
          r_match++;
      end
      if (busy) r_nb++;
      if (done) begin
        r_nd++;
        r_didx = i;
      end
      cfg_we = (i == we_at);
      cfg_pattern = wpat;
      stall_i = (i >= st_at) &&
                (i < st_at + st_len);
      if (i == sa_at) begin
        start = 1'b1;
        repeat_n = 8'd5;
        gap_n = 4'd3;
      end
      if (rst_at > 0 && i == rst_at) begin
        rst = 1'b0;
        #1;
        chk("abort_d", int'(d_o), 0);
        chk("abort_v", int'(v_o), 0);
        chk("abort_busy", int'(busy), 0);
      end
      if (rst_at > 0 && i == rst_at + 1)
        rst = 1'b1;
    end
    cfg_we = 1'b0;
    stall_i = 1'b0;
    start = 1'b0;
  endtask

  int rnd_v;
  logic rst_pend;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_d", int'(d_o), 0);
    chk("rst_v", int'(v_o), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    burst(1, 0, 8, 0, 5'd0, 0, 0, 0, 0);
    chk("t1_bits", int'(r_bits), 'b01101);
    chk("t1_first", r_fv, 1);
    chk("t1_nv", r_nv, 5);
    chk("t1_busy", r_nb, 5);
    chk("t1_done_at", r_didx, 6);

    burst(3, 2, 24, 0, 5'd0, 0, 0, 0, 0);
    chk("t2_nv", r_nv, 15);
    chk("t2_busy", r_nb, 19);
    chk("t2_ndone", r_nd, 1);
    chk("t2_done_at", r_didx, 20);
    chk("t2_detect", r_match, 3);

    burst(1, 0, 8, 2, 5'b10011, 0, 0, 0, 0);
    chk("t3_old", int'(r_bits), 'b01101);
    burst(1, 0, 8, 0, 5'd0, 0, 0, 0, 0);
    chk("t3_new", int'(r_bits), 'b10011);

    burst(1, 0, 12, 0, 5'd0, 2, 3, 0, 0);
    chk("t4_bits", int'(r_bits), 'b10011);
    chk("t4_nv", r_nv, 5);
    chk("t4_done_at", r_didx, 9);

    burst(3, 0, 20, 0, 5'd0, 0, 0, 7, 0);
    chk("t5_ndone", r_nd, 0);
    chk("t5_nv", r_nv, 7);
    burst(1, 0, 8, 0, 5'd0, 0, 0, 0, 0);
    chk("t5_default", int'(r_bits), 'b01101);

    burst(0, 0, 4, 0, 5'd0, 0, 0, 0, 0);
    chk("t6_nv", r_nv, 0);
    chk("t6_busy", r_nb, 0);
    chk("t6_done_at", r_didx, 1);
    burst(2, 1, 16, 0, 5'd0, 0, 0, 0, 3);
    chk("t6_ign_busy", r_nb, 11);
    chk("t6_ign_nv", r_nv, 10);
    chk("t6_ign_done", r_nd, 1);

    rnd_v = 0;
    rst_pend = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (v_o) rnd_v++;
      if (rst_pend) begin
        rst = 1'b1;
        rst_pend = 1'b0;
      end else if ($urandom_range(0, 599) == 0)
      begin
        rst = 1'b0;
        rst_pend = 1'b1;
      end
      start = ($urandom_range(0, 7) == 0);
      repeat_n = CNT_W'($urandom_range(0, 4));
      gap_n = GAP_W'($urandom_range(0, 3));
      stall_i = ($urandom_range(0, 4) == 0);
      cfg_we = ($urandom_range(0, 19) == 0);
      cfg_pattern = PAT_W'($urandom);
    end
    rst = 1'b1;
    chk("rnd_active", int'(rnd_v > 100), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
